// File: rtl/logic_pkg.sv
// Shared definitions for the pipelined logic unit: command codes, flag bundle
// and a constant width helper.
package logic_pkg;

  localparam logic [4:0] LOGIC_BUF0    = 5'h00;
  localparam logic [4:0] LOGIC_BUF1    = 5'h01;
  localparam logic [4:0] LOGIC_NOT0    = 5'h02;
  localparam logic [4:0] LOGIC_NOT1    = 5'h03;
  localparam logic [4:0] LOGIC_AND     = 5'h04;
  localparam logic [4:0] LOGIC_OR      = 5'h05;
  localparam logic [4:0] LOGIC_XOR     = 5'h06;
  localparam logic [4:0] LOGIC_NAND    = 5'h07;
  localparam logic [4:0] LOGIC_NOR     = 5'h08;
  localparam logic [4:0] LOGIC_XNOR    = 5'h09;
  localparam logic [4:0] LOGIC_BSET    = 5'h0A;
  localparam logic [4:0] LOGIC_BCLR    = 5'h0B;
  localparam logic [4:0] LOGIC_BREV    = 5'h0C;
  localparam logic [4:0] LOGIC_BYTEREV = 5'h0D;
  localparam logic [4:0] LOGIC_GETBIT  = 5'h0E;
  localparam logic [4:0] LOGIC_GETNIB  = 5'h0F;
  localparam logic [4:0] LOGIC_LIL     = 5'h10;
  localparam logic [4:0] LOGIC_LIH     = 5'h11;
  localparam logic [4:0] LOGIC_SEXT16  = 5'h12;
  localparam logic [4:0] LOGIC_ZEXT16  = 5'h14;
  localparam logic [4:0] LOGIC_POPCNT  = 5'h15;
  localparam logic [4:0] LOGIC_CLZ     = 5'h16;
  localparam logic [4:0] LOGIC_CTZ     = 5'h17;

  typedef struct packed {
    logic sf;
    logic of;
    logic cf;
    logic pf;
    logic zf;
  } logic_flags_t;

  function automatic int logic_clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
      else w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/logic_core_n.sv
// Combinational N-bit logic operation core: (cmd, d0, d1) -> (result, flags).
// Bit-count operations are present only when LOGIC_PIPE_BITCOUNT_EN is defined.
module logic_core_n
  import logic_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [4:0]   cmd_i,
  input  logic [N-1:0] d0_i,
  input  logic [N-1:0] d1_i,
  output logic [N-1:0] result_o,
  output logic_flags_t flags_o
);

  localparam int IW = logic_clog2(N);

  logic [IW-1:0] idx;
  logic [N-1:0]  bit_mask;
  logic [N-1:0]  shifted;
  logic [N-1:0]  bit_rev;
  logic [N-1:0]  byte_rev;
  logic [N-1:0]  half_ins;

  // Index is taken modulo N simply by using the low log2(N) bits.
  assign idx      = d1_i[IW-1:0];
  assign bit_mask = {{(N-1){1'b0}}, 1'b1} << idx;
  assign shifted  = d0_i >> idx;

  if (N > 32) begin : g_lih_wide
    assign half_ins = {d0_i[N-1:32], d1_i[15:0], d0_i[15:0]};
  end else begin : g_lih_narrow
    assign half_ins = {d1_i[15:0], d0_i[15:0]};
  end

  // Width-generic bit and byte reversal networks.
  always_comb begin
    bit_rev  = '0;
    byte_rev = '0;
    for (int i = 0; i < N; i++) bit_rev[i] = d0_i[N-1-i];
    for (int j = 0; j < N / 8; j++) byte_rev[8*j +: 8] = d0_i[N-8-8*j +: 8];
  end

`ifdef LOGIC_PIPE_BITCOUNT_EN
  logic [N-1:0] pop_cnt;
  logic [N-1:0] clz_cnt;
  logic [N-1:0] ctz_cnt;

  // Population count and leading/trailing zero counts; all-zero input gives N.
  always_comb begin
    pop_cnt = '0;
    clz_cnt = N'(N);
    ctz_cnt = N'(N);
    for (int i = 0; i < N; i++) begin
      pop_cnt = pop_cnt + N'(d0_i[i]);
      if (d0_i[i]) clz_cnt = N'(N - 1 - i);
      else clz_cnt = clz_cnt;
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (d0_i[i]) ctz_cnt = N'(i);
      else ctz_cnt = ctz_cnt;
    end
  end
`endif

  // Operation select.
  always_comb begin
    result_o = d0_i;
    case (cmd_i)
      LOGIC_BUF0:    result_o = d0_i;
      LOGIC_BUF1:    result_o = d1_i;
      LOGIC_NOT0:    result_o = ~d0_i;
      LOGIC_NOT1:    result_o = ~d1_i;
      LOGIC_AND:     result_o = d0_i & d1_i;
      LOGIC_OR:      result_o = d0_i | d1_i;
      LOGIC_XOR:     result_o = d0_i ^ d1_i;
      LOGIC_NAND:    result_o = ~(d0_i & d1_i);
      LOGIC_NOR:     result_o = ~(d0_i | d1_i);
      LOGIC_XNOR:    result_o = ~(d0_i ^ d1_i);
      LOGIC_BSET:    result_o = d0_i | bit_mask;
      LOGIC_BCLR:    result_o = d0_i & ~bit_mask;
      LOGIC_BREV:    result_o = bit_rev;
      LOGIC_BYTEREV: result_o = byte_rev;
      LOGIC_GETBIT:  result_o = {{(N-1){1'b0}}, d0_i[idx]};
      LOGIC_GETNIB:  result_o = {{(N-4){1'b0}}, shifted[3:0]};
      LOGIC_LIL:     result_o = {d0_i[N-1:16], d1_i[15:0]};
      LOGIC_LIH:     result_o = half_ins;
      LOGIC_SEXT16:  result_o = {{(N-16){d1_i[15]}}, d1_i[15:0]};
      LOGIC_ZEXT16:  result_o = {{(N-16){1'b0}}, d1_i[15:0]};
`ifdef LOGIC_PIPE_BITCOUNT_EN
      LOGIC_POPCNT:  result_o = pop_cnt;
      LOGIC_CLZ:     result_o = clz_cnt;
      LOGIC_CTZ:     result_o = ctz_cnt;
`endif
      default:       result_o = d0_i;
    endcase
  end

  // Flags derived from the result; overflow and carry are always clear.
  always_comb begin
    flags_o    = '0;
    flags_o.sf = result_o[N-1];
    flags_o.of = 1'b0;
    flags_o.cf = 1'b0;
    flags_o.pf = result_o[0];
    flags_o.zf = (result_o == '0);
  end

endmodule

// File: rtl/logic_pipe_n.sv
// Two-stage pipelined logic unit with valid/busy handshake, flush and tag.
// Optional bit-count operations are enabled by defining LOGIC_PIPE_BITCOUNT_EN.
module logic_pipe_n
  import logic_pkg::*;
#(
  parameter int N    = 32,
  parameter int TAGW = 6
) (
  input  logic            iCLOCK,
  input  logic            inRESET,
  input  logic            iREMOVE,
  input  logic            iVALID,
  output logic            oBUSY,
  input  logic [4:0]      iCMD,
  input  logic [N-1:0]    iDATA_0,
  input  logic [N-1:0]    iDATA_1,
  input  logic [TAGW-1:0] iTAG,
  output logic            oVALID,
  input  logic            iBUSY,
  output logic [N-1:0]    oDATA,
  output logic [TAGW-1:0] oTAG,
  output logic            oSF,
  output logic            oOF,
  output logic            oCF,
  output logic            oPF,
  output logic            oZF
);

  logic            s1_valid_q, s1_valid_d;
  logic            s2_valid_q, s2_valid_d;
  logic [4:0]      s1_cmd_q;
  logic [N-1:0]    s1_d0_q, s1_d1_q;
  logic [TAGW-1:0] s1_tag_q, s2_tag_q;
  logic [N-1:0]    s2_data_q;
  logic_flags_t    s2_flags_q;

  logic            s2_load, accept;
  logic [N-1:0]    core_result;
  logic_flags_t    core_flags;

  assign s2_load = !s2_valid_q || !iBUSY;
  assign oBUSY   = s1_valid_q && s2_valid_q && iBUSY;
  assign accept  = iVALID && !oBUSY && !iREMOVE;

  logic_core_n #(.N(N)) u_core (
    .cmd_i    (s1_cmd_q),
    .d0_i     (s1_d0_q),
    .d1_i     (s1_d1_q),
    .result_o (core_result),
    .flags_o  (core_flags)
  );

  // Stage valid next-state; flush wins over any accept or advance.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (iREMOVE) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (accept) s1_valid_d = 1'b1;
      else if (s2_load) s1_valid_d = 1'b0;
      else s1_valid_d = s1_valid_q;
      if (s2_load) s2_valid_d = s1_valid_q;
      else s2_valid_d = s2_valid_q;
    end
  end

  // Valid registers.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Stage 1 captures the request only when it is accepted.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      s1_cmd_q <= 5'h00;
      s1_d0_q  <= '0;
      s1_d1_q  <= '0;
      s1_tag_q <= '0;
    end else if (accept) begin
      s1_cmd_q <= iCMD;
      s1_d0_q  <= iDATA_0;
      s1_d1_q  <= iDATA_1;
      s1_tag_q <= iTAG;
    end else begin
      s1_cmd_q <= s1_cmd_q;
    end
  end

  // Stage 2 holds its result while the consumer stalls.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
      s2_flags_q <= '0;
    end else if (s2_load && s1_valid_q && !iREMOVE) begin
      s2_data_q  <= core_result;
      s2_tag_q   <= s1_tag_q;
      s2_flags_q <= core_flags;
    end else begin
      s2_data_q  <= s2_data_q;
    end
  end

  assign oVALID = s2_valid_q;
  assign oDATA  = s2_data_q;
  assign oTAG   = s2_tag_q;
  assign oSF    = s2_flags_q.sf;
  assign oOF    = s2_flags_q.of;
  assign oCF    = s2_flags_q.cf;
  assign oPF    = s2_flags_q.pf;
  assign oZF    = s2_flags_q.zf;

endmodule

// File: tb/tb_logic_pipe_n.sv
// Self-checking bench for logic_pipe_n at N=32 (pipeline behaviour) and N=64
// (width-generic operations), against an in-bench operation/queue model.
module tb_logic_pipe_n;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // N=32 instance signals
  logic        rem32 = 1'b0, vld32 = 1'b0, ibusy32 = 1'b0;
  logic [4:0]  cmd32 = 5'h00;
  logic [31:0] d0_32 = 32'h0, d1_32 = 32'h0;
  logic [5:0]  tag32 = 6'h0;
  logic        oBUSY32, oVALID32, oSF32, oOF32, oCF32, oPF32, oZF32;
  logic [31:0] oDATA32;
  logic [5:0]  oTAG32;

  // N=64 instance signals
  logic        rem64 = 1'b0, vld64 = 1'b0, ibusy64 = 1'b0;
  logic [4:0]  cmd64 = 5'h00;
  logic [63:0] d0_64 = 64'h0, d1_64 = 64'h0;
  logic [5:0]  tag64 = 6'h0;
  logic        oBUSY64, oVALID64, oSF64, oOF64, oCF64, oPF64, oZF64;
  logic [63:0] oDATA64;
  logic [5:0]  oTAG64;

  logic_pipe_n #(.N(32), .TAGW(6)) dut32 (
    .iCLOCK(clk), .inRESET(rst_n), .iREMOVE(rem32), .iVALID(vld32), .oBUSY(oBUSY32),
    .iCMD(cmd32), .iDATA_0(d0_32), .iDATA_1(d1_32), .iTAG(tag32), .oVALID(oVALID32),
    .iBUSY(ibusy32), .oDATA(oDATA32), .oTAG(oTAG32),
    .oSF(oSF32), .oOF(oOF32), .oCF(oCF32), .oPF(oPF32), .oZF(oZF32)
  );

  logic_pipe_n #(.N(64), .TAGW(6)) dut64 (
    .iCLOCK(clk), .inRESET(rst_n), .iREMOVE(rem64), .iVALID(vld64), .oBUSY(oBUSY64),
    .iCMD(cmd64), .iDATA_0(d0_64), .iDATA_1(d1_64), .iTAG(tag64), .oVALID(oVALID64),
    .iBUSY(ibusy64), .oDATA(oDATA64), .oTAG(oTAG64),
    .oSF(oSF64), .oOF(oOF64), .oCF(oCF64), .oPF(oPF64), .oZF(oZF64)
  );

  typedef struct {
    logic [31:0] d;
    logic [5:0]  tag;
    bit          vis;
  } ent_t;

  ent_t pq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Operation reference written from the operation table with plain arithmetic.
  function automatic logic [63:0] ref_op(input int n, input logic [4:0] cmd,
                                         input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] m, a, b, r;
    int idx, c;
    m   = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a   = a_in & m;
    b   = b_in & m;
    idx = int'(b[5:0]) % n;
    r   = 64'd0;
    c   = 0;
    case (cmd)
      5'h00: r = a;
      5'h01: r = b;
      5'h02: r = ~a;
      5'h03: r = ~b;
      5'h04: r = a & b;
      5'h05: r = a | b;
      5'h06: r = a ^ b;
      5'h07: r = ~(a & b);
      5'h08: r = ~(a | b);
      5'h09: r = ~(a ^ b);
      5'h0A: r = a | (64'd1 << idx);
      5'h0B: r = a & ~(64'd1 << idx);
      5'h0C: for (int i = 0; i < n; i++) r[n-1-i] = a[i];
      5'h0D: for (int j = 0; j < n / 8; j++) r[8*(n/8-1-j) +: 8] = a[8*j +: 8];
      5'h0E: r = (a >> idx) & 64'd1;
      5'h0F: r = (a >> idx) & 64'd15;
      5'h10: r = (a & ~64'hFFFF) | (b & 64'hFFFF);
      5'h11: r = ((n == 64) ? (a & 64'hFFFF_FFFF_0000_0000) : 64'd0)
                 | ((b & 64'hFFFF) << 16) | (a & 64'hFFFF);
      5'h12: r = b[15] ? ((b & 64'hFFFF) | ~64'hFFFF) : (b & 64'hFFFF);
      5'h14: r = b & 64'hFFFF;
`ifdef LOGIC_PIPE_BITCOUNT_EN
      5'h15: r = 64'($countones(a));
      5'h16: begin
        while (c < n && !a[n-1-c]) c++;
        r = 64'(c);
      end
      5'h17: begin
        while (c < n && !a[c]) c++;
        r = 64'(c);
      end
`endif
      default: r = a;
    endcase
    return r & m;
  endfunction

  function automatic logic [4:0] ref_flags(input int n, input logic [63:0] r);
    return {r[n-1], 1'b0, 1'b0, r[0], (r == 64'd0)};
  endfunction

  // One cycle on the N=32 unit: drive, check oBUSY, clock, update model, check outputs.
  task automatic step32(input bit v, input logic [4:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] t, input bit busy,
                        input bit rem, output bit acc);
    bit exp_busy, exp_v;
    ent_t e;
    logic [63:0] r;
    vld32 = v; cmd32 = c; d0_32 = a; d1_32 = b; tag32 = t; ibusy32 = busy; rem32 = rem;
    #1;
    exp_busy = (pq.size() == 2) && busy;
    check("obusy", 64'(oBUSY32), 64'(exp_busy));
    acc = v && !exp_busy && !rem;
    @(posedge clk);
    if (rem) begin
      pq.delete();
    end else begin
      if (pq.size() > 0 && pq[0].vis && !busy) void'(pq.pop_front());
      if (pq.size() > 0 && !pq[0].vis) pq[0].vis = 1'b1;
      if (acc) begin
        r     = ref_op(32, c, {32'd0, a}, {32'd0, b});
        e.d   = r[31:0];
        e.tag = t;
        e.vis = 1'b0;
        pq.push_back(e);
      end
    end
    #1;
    exp_v = (pq.size() > 0) && pq[0].vis;
    check("ovalid", 64'(oVALID32), 64'(exp_v));
    if (exp_v) begin
      check("odata", 64'(oDATA32), 64'(pq[0].d));
      check("otag", 64'(oTAG32), 64'(pq[0].tag));
      check("flags", 64'({oSF32, oOF32, oCF32, oPF32, oZF32}),
            64'(ref_flags(32, {32'd0, pq[0].d})));
    end
  endtask

  task automatic single32(input string tag, input logic [4:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic [4:0] fl);
    bit acc;
    step32(1'b1, c, a, b, 6'h2A, 1'b0, 1'b0, acc);
    step32(1'b0, 5'h00, 32'h0, 32'h0, 6'h00, 1'b0, 1'b0, acc);
    check(tag, 64'(oDATA32), 64'(exp));
    check({tag, "_flg"}, 64'({oSF32, oOF32, oCF32, oPF32, oZF32}), 64'(fl));
    check({tag, "_tag"}, 64'(oTAG32), 64'h2A);
    step32(1'b0, 5'h00, 32'h0, 32'h0, 6'h00, 1'b0, 1'b0, acc);
  endtask

  task automatic op64(input string tag, input logic [4:0] c, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] exp);
    vld64 = 1'b1; cmd64 = c; d0_64 = a; d1_64 = b; tag64 = 6'h15;
    @(posedge clk); #1;
    vld64 = 1'b0;
    check({tag, "_lat"}, 64'(oVALID64), 64'd0);
    @(posedge clk); #1;
    check({tag, "_vld"}, 64'(oVALID64), 64'd1);
    check(tag, oDATA64, exp);
    check({tag, "_tag"}, 64'(oTAG64), 64'h15);
    check({tag, "_flg"}, 64'({oSF64, oOF64, oCF64, oPF64, oZF64}), 64'(ref_flags(64, exp)));
    @(posedge clk); #1;
  endtask

  initial begin
    bit acc, have, busy, rem;
    logic [4:0]  c;
    logic [31:0] a, b;
    logic [63:0] a64, b64;
    logic [5:0]  t;
    int guard;

    // Reset
    #2 rst_n = 1'b0;
    #20;
    check("rst_ovalid32", 64'(oVALID32), 64'd0);
    check("rst_odata32", 64'(oDATA32), 64'd0);
    check("rst_otag32", 64'(oTAG32), 64'd0);
    check("rst_flags32", 64'({oSF32, oOF32, oCF32, oPF32, oZF32}), 64'd0);
    check("rst_obusy32", 64'(oBUSY32), 64'd0);
    check("rst_ovalid64", 64'(oVALID64), 64'd0);
    check("rst_odata64", oDATA64, 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed N=32 operations and latency
    single32("and_lat", 5'h04, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b10000);
    single32("getnib", 5'h0F, 32'hA0000000, 32'd30, 32'h00000002, 5'b00000);
    single32("undef13", 5'h13, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 5'b00000);
    single32("zero_zf", 5'h00, 32'h0, 32'h5, 32'h0, 5'b00001);
`ifdef LOGIC_PIPE_BITCOUNT_EN
    single32("popcnt", 5'h15, 32'hFFFF0000, 32'h0, 32'd16, 5'b00000);
    single32("clz", 5'h16, 32'h00010000, 32'h0, 32'd15, 5'b00010);
    single32("ctz0", 5'h17, 32'h0, 32'h0, 32'd32, 5'b00000);
`else
    single32("popcnt_off", 5'h15, 32'hFFFF0000, 32'h0, 32'hFFFF0000, 5'b10000);
    single32("clz_off", 5'h16, 32'h00010000, 32'h0, 32'h00010000, 5'b00000);
    single32("ctz_off", 5'h17, 32'h0, 32'h0, 32'h0, 5'b00001);
`endif

    // Stall: three back-to-back requests under downstream busy
    step32(1'b1, 5'h00, 32'h111, 32'h0, 6'd1, 1'b1, 1'b0, acc);
    step32(1'b1, 5'h00, 32'h222, 32'h0, 6'd2, 1'b1, 1'b0, acc);
    step32(1'b1, 5'h00, 32'h333, 32'h0, 6'd3, 1'b1, 1'b0, acc);
    check("stall_acc3", 64'(acc), 64'd0);
    check("stall_obusy", 64'(oBUSY32), 64'd1);
    check("stall_hold", 64'(oDATA32), 64'h111);
    step32(1'b1, 5'h00, 32'h333, 32'h0, 6'd3, 1'b1, 1'b0, acc);
    check("stall_hold2", 64'(oDATA32), 64'h111);
    guard = 0;
    do begin
      step32(1'b1, 5'h00, 32'h333, 32'h0, 6'd3, 1'b0, 1'b0, acc);
      guard++;
    end while (!acc && guard < 6);
    check("stall_accept3", 64'(acc), 64'd1);
    for (int i = 0; i < 4; i++) step32(1'b0, 5'h00, 32'h0, 32'h0, 6'd0, 1'b0, 1'b0, acc);
    check("stall_drained", 64'(oVALID32), 64'd0);

    // Flush with both stages full and a request offered
    step32(1'b1, 5'h05, 32'hAAAA, 32'h1, 6'd7, 1'b1, 1'b0, acc);
    step32(1'b1, 5'h06, 32'hBBBB, 32'h2, 6'd8, 1'b1, 1'b0, acc);
    step32(1'b1, 5'h07, 32'hCCCC, 32'h3, 6'd9, 1'b1, 1'b1, acc);
    check("flush_ovalid", 64'(oVALID32), 64'd0);
    for (int i = 0; i < 4; i++) step32(1'b0, 5'h00, 32'h0, 32'h0, 6'd0, 1'b0, 1'b0, acc);

    // Randomized traffic with stalls and occasional flushes
    have = 1'b0; c = 5'h0; a = 32'h0; b = 32'h0; t = 6'h0;
    for (int i = 0; i < 400; i++) begin
      if (!have) begin
        have = ($urandom_range(0, 3) != 0);
        c = 5'($urandom_range(0, 31));
        a = $urandom;
        b = $urandom;
        t = 6'($urandom);
      end
      busy = ($urandom_range(0, 2) == 0);
      rem  = ($urandom_range(0, 40) == 0);
      step32(have, c, a, b, t, busy, rem, acc);
      if (acc || rem) have = 1'b0;
    end
    for (int i = 0; i < 4; i++) step32(1'b0, 5'h00, 32'h0, 32'h0, 6'd0, 1'b0, 1'b0, acc);

    // Width-generic operations at N=64
    op64("brev64", 5'h0C, 64'h0000000000000001, 64'h0, 64'h8000000000000000);
    op64("byterev64", 5'h0D, 64'h0102030405060708, 64'h0, 64'h0807060504030201);
    op64("bset64", 5'h0A, 64'h0, 64'd70, 64'h0000000000000040);
    op64("lih64", 5'h11, 64'h1122334455667788, 64'h00000000AAAABBBB, 64'h11223344BBBB7788);
    for (int i = 0; i < 24; i++) begin
      c   = 5'($urandom_range(0, 31));
      a64 = {$urandom, $urandom};
      b64 = {$urandom, $urandom};
      op64("rand64", c, a64, b64, ref_op(64, c, a64, b64));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_pipe_n.md
Name: logic_pipe_n

Overview:
Parametrised, pipelined successor to the execute-stage logic unit. It has a 2-register pipeline with a valid/busy handshake, downstream stall, flush, and a tag that passes through unchanged.
- Operations are generalised to N bits, with bit reverse, byte reverse and bit indexing correct at any width.
- Sits between the dispatch and writeback stages of the execute unit.

Parameters:
N, 32, datapath width; legal values 32 or 64
TAGW, 6, width of the pass-through tag (destination/ROB id)

Ports:
iCLOCK  in  1  clock, rising edge
inRESET  in  1  asynchronous active-low reset
iREMOVE  in  1  synchronous flush of all in-flight entries
iVALID  in  1  request valid
oBUSY  out  1  cannot accept a request this cycle
iCMD  in  5  operation code
iDATA_0  in  N  operand 0
iDATA_1  in  N  operand 1
iTAG  in  TAGW  request tag
oVALID  out  1  result valid
iBUSY  in  1  downstream stall
oDATA  out  N  result
oTAG  out  TAGW  tag of the result
oSF/oOF/oCF/oPF/oZF  out  1 each  flags

Behaviour:
- One clock, iCLOCK; inRESET is asynchronous, active-low.
- Reset: both stage valids = 0; oVALID=0; oDATA, oTAG and all flags = 0.
- Stage S1 registers cmd, operands and tag. Stage S2 registers the computed result, flags and tag. Outputs are driven from S2.
- Latency is 2 cycles with no stall: iVALID&&!oBUSY at edge k gives oVALID at edge k+2. Throughput is 1 per cycle.
- S2 loads when !S2.valid || !iBUSY. S1 advances when S2 loads.
- oBUSY = S1.valid && S2.valid && iBUSY. This is combinational, with no dependence on iVALID.
- With iVALID=1 while oBUSY=1, the request is ignored and the requester holds it.
- While oVALID && iBUSY, oDATA, oTAG and the flags stay stable.
- iREMOVE: at the next edge both valids = 0. It beats a same-cycle accept, and the request offered in that cycle is dropped.
- Data registers load only on accept; don't-care when invalid.
- Operations (d0, d1; idx = d1[log2N-1:0], i.e. index modulo N):
  - 0x0/0x1: d0/d1
  - 0x2/0x3: ~d0/~d1
  - 0x4-0x9: AND, OR, XOR, NAND, NOR, XNOR
  - 0xA: d0 | (1<<idx)
  - 0xB: d0 & ~(1<<idx)
  - 0xC: full N-bit bit reverse
  - 0xD: byte reverse over N/8 bytes
  - 0xE: zero-extended d0[idx]
  - 0xF: zero-extended (d0>>idx)[3:0]; bits beyond N-1 read 0
  - 0x10: {d0[N-1:16], d1[15:0]}
  - 0x11: {d0[N-1:32] (only when N=64), d1[15:0], d0[15:0]}
  - 0x12: sign-extend d1[15:0]
  - 0x14: zero-extend d1[15:0]
  - all other codes: d0
- Flags from the S2 result:
  - SF = result[N-1]
  - PF = result[0]
  - ZF = (result==0)
  - OF = CF = 0

Optional Feature:
LOGIC_PIPE_BITCOUNT_EN:
- Defined: adds three operations, each with the result zero-extended.
  - 0x15: popcount(d0)
  - 0x16: count leading zeros(d0); d0=0 gives N
  - 0x17: count trailing zeros(d0); d0=0 gives N
  - Latency is unchanged; the counters are computed in S2.
- Undefined: 0x15-0x17 fall into the default (d0); no extra logic.

Decomposition:
- Package logic_pkg:
  - 5-bit command code constants LOGIC_BUF0..LOGIC_CTZ
  - clog2 width helper constant function
  - flag struct typedef {sf, of, cf, pf, zf}
- Sub-module logic_core_n: purely combinational, (cmd, d0, d1) -> (result, flags), parametrised by N. The pipe instantiates it between S1 and S2.

Test Plan:
- Reset/latency (N=32): release inRESET, drive cmd 0x4 with d0=F0F0F0F0, d1=FF00FF00 for 1 cycle -> oVALID exactly 2 cycles later, oDATA=F000F000, SF=1, ZF=0, PF=0, oTAG echoed.
- Width-generic ops (N=64):
  - 0xC on 0x0000000000000001 -> 0x8000000000000000.
  - 0xD on 0x0102030405060708 -> 0x0807060504030201.
  - 0xA with d0=0, d1=70 -> bit 6 set (idx modulo 64).
- Stall: hold iBUSY=1 while streaming 3 back-to-back requests -> oBUSY asserts on the 3rd cycle, oDATA holds the first result; drop iBUSY -> all 3 results in order, none lost or duplicated.
- Flush: iREMOVE=1 with both stages valid and iVALID=1 -> oVALID=0 next cycle, and no result ever appears for any of the three.
- Boundaries:
  - 0xF with d0=0xA0000000, d1=30 -> 0x2.
  - Undefined cmd 0x13 with d0=0x12345678 -> 0x12345678.
  - 0x0 with d0=0 -> ZF=1.
- With LOGIC_PIPE_BITCOUNT_EN:
  - 0x15 on FFFF0000 -> 16.
  - 0x16 on 00010000 -> 15.
  - 0x17 on 0 -> 32.
  - Without the macro, 0x16 on 00010000 -> 00010000.
